// File: rtl/phase_countdown_display.sv
// Per-second countdown of the current traffic-light phase, shown on a 2-digit
// multiplexed active-low 7-segment display. Optional blink: PHASE_COUNTDOWN_BLINK_EN.
module phase_countdown_display #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  led,
    input  logic [11:0] sw_led,
    output logic [3:0]  remaining,
    output logic        expired,
    output logic [6:0]  seg,
    output logic [1:0]  an
);

    // phase (led_q) | meaning
    // PH_OFF        | lights off, display blank, countdown idle
    // PH_GREEN      | counting down sw_led[3:0]
    // PH_YELLOW     | counting down sw_led[7:4]
    // PH_RED        | counting down sw_led[11:8]
    localparam logic [1:0] PH_OFF    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_RED    = 2'b11;

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
`ifdef PHASE_COUNTDOWN_BLINK_EN
    localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(TICK_DIV / 2 - 1);
`endif

    logic [1:0]        led_q;
    logic [PRE_W-1:0]  prescaler;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_sel;

    logic              load;
    logic              running;
    logic              tick;
    logic [3:0]        load_val;
    logic [3:0]        rem_n;
    logic              exp_n;
    logic [PRE_W-1:0]  pre_n;
    logic              scan_wrap;
    logic [SCAN_W-1:0] scan_cnt_n;
    logic              sel_n;
    logic              tens_n;
    logic [3:0]        units_n;
    logic [3:0]        digit;
    logic              blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign load    = (led != led_q);
    assign running = (led_q != PH_OFF) && (remaining != 4'd0);
    assign tick    = running && (prescaler == PRE_LAST);

    always_comb begin
        load_val = 4'd0;
        case (led)
            PH_GREEN:  load_val = sw_led[3:0];
            PH_YELLOW: load_val = sw_led[7:4];
            PH_RED:    load_val = sw_led[11:8];
            default:   load_val = 4'd0;
        endcase
    end

    // A phase change outranks a coincident tick: reload, no decrement, no pulse.
    always_comb begin
        rem_n = remaining;
        exp_n = 1'b0;
        pre_n = '0;
        if (load) begin
            rem_n = load_val;
        end else if (tick) begin
            rem_n = remaining - 4'd1;
            exp_n = (remaining == 4'd1);
        end else if (running) begin
            pre_n = prescaler + 1'b1;
        end
    end

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign scan_cnt_n = scan_wrap ? '0 : scan_cnt + 1'b1;
    assign sel_n      = scan_wrap ? ~scan_sel : scan_sel;

    // Display is decoded from next-state values so seg/an line up with remaining.
    assign tens_n  = (rem_n >= 4'd10);
    assign units_n = tens_n ? (rem_n - 4'd10) : rem_n;
    assign digit   = sel_n ? {3'b000, tens_n} : units_n;

`ifdef PHASE_COUNTDOWN_BLINK_EN
    logic blink_q;
    logic blink_n;

    always_comb begin
        blink_n = blink_q;
        if (load) begin
            blink_n = 1'b0;
        end else if (running && ((prescaler == PRE_HALF) || (prescaler == PRE_LAST))) begin
            blink_n = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_n;
        end
    end

    assign blank = (led == PH_OFF) || (sel_n && !tens_n) ||
                   (blink_n && (rem_n >= 4'd1) && (rem_n <= 4'd3));
`else
    assign blank = (led == PH_OFF) || (sel_n && !tens_n);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q     <= PH_OFF;
            prescaler <= '0;
            remaining <= 4'd0;
            expired   <= 1'b0;
            scan_cnt  <= '0;
            scan_sel  <= 1'b0;
            an        <= 2'b11;
            seg       <= 7'h7F;
        end else begin
            led_q     <= led;
            prescaler <= pre_n;
            remaining <= rem_n;
            expired   <= exp_n;
            scan_cnt  <= scan_cnt_n;
            scan_sel  <= sel_n;
            an        <= sel_n ? 2'b01 : 2'b10;
            seg       <= blank ? 7'h7F : seg_decode(digit);
        end
    end

endmodule

// File: tb/tb_phase_countdown_display.sv
// Scoreboard bench for phase_countdown_display with TICK_DIV=4, SCAN_DIV=2.
module tb_phase_countdown_display;

    logic        clk;
    logic        rst;
    logic [1:0]  led;
    logic [11:0] sw_led;
    logic [3:0]  remaining;
    logic        expired;
    logic [6:0]  seg;
    logic [1:0]  an;

`ifdef PHASE_COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    phase_countdown_display #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .led(led), .sw_led(sw_led),
        .remaining(remaining), .expired(expired), .seg(seg), .an(an)
    );

    typedef struct {
        int         cyc;
        logic [3:0] rem;
        logic       exp;
    } evt_t;

    evt_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] prev_rem = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [6:0] dec(input int d);
        case (d)
            0: dec = 7'h40;  1: dec = 7'h79;  2: dec = 7'h24;  3: dec = 7'h30;
            4: dec = 7'h19;  5: dec = 7'h12;  6: dec = 7'h02;  7: dec = 7'h78;
            8: dec = 7'h00;  9: dec = 7'h10;  default: dec = 7'h7F;
        endcase
    endfunction

    task automatic push_evt(input int c, input logic [3:0] r, input logic x);
        evt_t e;
        e.cyc = c; e.rem = r; e.exp = x;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // tens < 0 means the tens digit is expected blank
    task automatic check_disp(input string name, input int units, input int tens, input bit all_blank);
        logic [6:0] e;
        chk({name, "_an"}, {31'd0, (an == 2'b10) || (an == 2'b01)}, 32'd1);
        if (an == 2'b01) e = (tens < 0 || all_blank) ? 7'h7F : dec(tens);
        else             e = all_blank ? 7'h7F : dec(units);
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, e});
    endtask

    // Monitor: every change of remaining, or any expired pulse, is an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (remaining !== prev_rem || expired !== 1'b0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: cycle %0d remaining=%0d expired=%0b, expected no event",
                             cyc, remaining, expired);
                end else begin
                    evt_t e;
                    e = sb.pop_front();
                    chk("evt_cycle", cyc, e.cyc);
                    chk("evt_remaining", {28'd0, remaining}, {28'd0, e.rem});
                    chk("evt_expired", {31'd0, expired}, {31'd0, e.exp});
                end
            end
            prev_rem = remaining;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   m;
        int   p;
        logic [1:0] ans [8];

        rst    = 1'b0;
        led    = 2'($urandom_range(3, 0));
        sw_led = 12'($urandom);
        repeat (3) begin
            step(1);
            chk("rst_remaining", {28'd0, remaining}, 32'd0);
            chk("rst_expired", {31'd0, expired}, 32'd0);
            chk("rst_seg", {25'd0, seg}, 32'h7F);
            chk("rst_an", {30'd0, an}, 32'd3);
            led    = 2'($urandom_range(3, 0));
            sw_led = 12'($urandom);
        end
        led      = 2'b00;
        prev_rem = 4'd0;
        mon_en   = 1'b1;
        rst      = 1'b1;
        step(4);
        chk("idle_remaining", {28'd0, remaining}, 32'd0);
        chk("idle_expired", {31'd0, expired}, 32'd0);
        chk("idle_seg", {25'd0, seg}, 32'h7F);

        // Green countdown 5..0
        n = cyc; sw_led = 12'hF35; led = 2'b01;
        push_evt(n + 1, 4'd5, 1'b0);
        push_evt(n + 5, 4'd4, 1'b0);
        push_evt(n + 9, 4'd3, 1'b0);
        push_evt(n + 13, 4'd2, 1'b0);
        push_evt(n + 17, 4'd1, 1'b0);
        push_evt(n + 21, 4'd0, 1'b1);
        wait_until(n + 1);
        check_disp("green5", 5, -1, 1'b0);
        wait_until(n + 30);
        chk("green_hold_remaining", {28'd0, remaining}, 32'd0);
        chk("green_hold_expired", {31'd0, expired}, 32'd0);

        // Two-digit red countdown from 12
        n = cyc; sw_led = 12'hC00; led = 2'b11;
        for (int k = 1; k <= 12; k++) push_evt(n + 1 + 4 * (k - 1), 4'(13 - k), 1'b0);
        push_evt(n + 49, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wait_until(n + 1 + i);
            ans[i] = an;
            check_disp(i < 4 ? "red12" : "red11", i < 4 ? 2 : 1, 1, 1'b0);
        end
        for (int i = 2; i < 8; i++) chk("an_scan_period", {31'd0, ans[i] != ans[i - 2]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_until(n + 13 + i);
            check_disp("red9", 9, -1, 1'b0);
        end
        wait_until(n + 52);

        // Phase change colliding with a tick at remaining=3
        n = cyc; sw_led = 12'h035; led = 2'b01;
        push_evt(n + 1, 4'd5, 1'b0);
        push_evt(n + 5, 4'd4, 1'b0);
        push_evt(n + 9, 4'd3, 1'b0);
        wait_until(n + 12);
        led = 2'b10;
        push_evt(n + 17, 4'd2, 1'b0);
        push_evt(n + 21, 4'd1, 1'b0);
        push_evt(n + 25, 4'd0, 1'b1);
        wait_until(n + 13);
        chk("collide_remaining", {28'd0, remaining}, 32'd3);
        chk("collide_expired", {31'd0, expired}, 32'd0);
        wait_until(n + 30);

        // Zero-duration yellow
        n = cyc; sw_led = 12'h402; led = 2'b01;
        push_evt(n + 1, 4'd2, 1'b0);
        wait_until(n + 2);
        led = 2'b10;
        push_evt(n + 3, 4'd0, 1'b0);
        wait_until(n + 3);
        chk("zero_remaining", {28'd0, remaining}, 32'd0);
        chk("zero_expired", {31'd0, expired}, 32'd0);
        wait_until(n + 12);

        // Red phase with sw_led changed mid-phase, plus blink window at 3
        m = cyc; led = 2'b11;
        push_evt(m + 1, 4'd4, 1'b0);
        push_evt(m + 5, 4'd3, 1'b0);
        push_evt(m + 9, 4'd2, 1'b0);
        push_evt(m + 13, 4'd1, 1'b0);
        push_evt(m + 17, 4'd0, 1'b1);
        wait_until(m + 2);
        sw_led = 12'h9A7;
        for (int i = 0; i < 4; i++) begin
            wait_until(m + 5 + i);
            check_disp("red3_blink", 3, -1, BLINK && (i >= 2));
        end
        wait_until(m + 22);

        // New sw_led takes effect at the next transition; then lights off
        p = cyc; led = 2'b01;
        push_evt(p + 1, 4'd7, 1'b0);
        wait_until(p + 1);
        check_disp("green7", 7, -1, 1'b0);
        wait_until(p + 2);
        led = 2'b00;
        push_evt(p + 3, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_until(p + 3 + i);
            chk("off_seg", {25'd0, seg}, 32'h7F);
        end
        step(4);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
